// File: rtl/noc_edge_sink_pkg.sv
// Shared definitions for the NoC mesh-edge sink: header field positions and FSM states.
package noc_edge_sink_pkg;

   localparam int LEN_LSB      = 22;
   localparam int LEN_MSB      = 29;
   localparam int LEN_W        = LEN_MSB - LEN_LSB + 1;
   localparam int MSG_TYPE_LSB = 14;
   localparam int MSG_TYPE_MSB = 21;
   localparam int DEST_X_LSB   = 42;
   localparam int DEST_X_MSB   = 49;
   localparam int DEST_Y_LSB   = 34;
   localparam int DEST_Y_MSB   = 41;
   localparam int CHIPID_LSB   = 50;
   localparam int CHIPID_MSB   = 63;

   typedef enum logic {
      HEADER  = 1'b0,
      PAYLOAD = 1'b1
   } sink_state_t;

endpackage

// File: rtl/noc_edge_sink_fifo.sv
// Input buffer for the edge sink; pointers carry one extra wrap bit to tell full from empty.
module noc_edge_sink_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/noc_edge_sink.sv
// Terminates a mesh-edge router output: consumes flits, returns credits, tracks framing, logs strays.
// Optional NOC_EDGE_SINK_TSTAMP_EN adds a cycle counter and err_tstamp output.
//
//   state   | meaning
//   HEADER  | next popped flit is a packet header; its len field sets the payload count
//   PAYLOAD | popping payload flits, remain counts those still expected
module noc_edge_sink
   import noc_edge_sink_pkg::*;
#(
   parameter int FLIT_W     = 64,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flit_in_val,
   input  logic [FLIT_W-1:0] flit_in_data,
   output logic              flit_in_yummy,
   input  logic              drain_en,
   input  logic              clear,
   output logic              err_valid,
   output logic [FLIT_W-1:0] err_header,
   output logic              ovf_err,
   output logic [CNT_W-1:0]  pkt_count,
   output logic [CNT_W-1:0]  flit_count
`ifdef NOC_EDGE_SINK_TSTAMP_EN
   ,output logic [CNT_W-1:0] err_tstamp
`endif
);

   logic              full;
   logic              empty;
   logic              pop;
   logic              push;
   logic              drop;
   logic              pkt_done;
   logic [FLIT_W-1:0] head;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  remain;
   sink_state_t       state;

   // A pop in the same cycle frees the slot, so a flit arriving at a full buffer is still taken.
   assign pop      = drain_en && !empty;
   assign push     = flit_in_val && (!full || pop);
   assign drop     = flit_in_val && full && !pop;
   assign len      = head[LEN_MSB:LEN_LSB];
   assign pkt_done = pop && (((state == HEADER) && (len == '0)) ||
                             ((state == PAYLOAD) && (remain == 8'd1)));

   noc_edge_sink_fifo #(
      .W     (FLIT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (flit_in_data),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= HEADER;
         remain        <= '0;
         flit_in_yummy <= 1'b0;
         err_valid     <= 1'b0;
         err_header    <= '0;
         ovf_err       <= 1'b0;
         pkt_count     <= '0;
         flit_count    <= '0;
      end else begin
         flit_in_yummy <= pop;

         if (pop) begin
            case (state)
               HEADER: begin
                  if (len != '0) begin
                     remain <= len;
                     state  <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  remain <= remain - 1'b1;
                  if (remain == 8'd1) state <= HEADER;
               end
               default: state <= HEADER;
            endcase
         end

         // Clear wins over any same-cycle update; framing above is unaffected.
         if (clear) begin
            err_valid  <= 1'b0;
            err_header <= '0;
            ovf_err    <= 1'b0;
            pkt_count  <= '0;
            flit_count <= '0;
         end else begin
            if (drop) ovf_err <= 1'b1;
            if (pop && (~&flit_count)) flit_count <= flit_count + 1'b1;
            if (pkt_done && (~&pkt_count)) pkt_count <= pkt_count + 1'b1;
            if (pop && (state == HEADER)) begin
               err_valid <= 1'b1;
               if (!err_valid) err_header <= head;
            end
         end
      end
   end

`ifdef NOC_EDGE_SINK_TSTAMP_EN
   logic [CNT_W-1:0] cyc_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt    <= '0;
         err_tstamp <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + 1'b1;
         if (clear)
            err_tstamp <= '0;
         else if (pop && (state == HEADER) && !err_valid)
            err_tstamp <= cyc_cnt;
      end
   end
`endif

endmodule
